fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID latch.
- Owns the PC register and issues instruction-memory reads.
- Drives the PC+4, instruction, enable and flush inputs of the IF/ID latch.
- Handles hazard-unit stalls, branch/jump redirects (including redirects that arrive during an outstanding imem miss) and halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, data/address width; fixed at 32 for this ISA

Ports:
CLK  input  1  system clock, rising-edge
nRST  input  1  asynchronous reset, active-high (nRST=1 resets)
ihit  input  1  imem read complete this cycle; imemload valid
imemload  input  WORD_W  instruction word returned by imem
stall  input  1  hazard unit: hold PC and IF/ID contents
redirect  input  1  taken branch/jump/jr resolved downstream
redirect_pc  input  WORD_W  target address for redirect
halt  input  1  HALT instruction detected downstream
imemREN  output  1  imem read enable
imemaddr  output  WORD_W  imem read address (= PC)
PC4_out  output  WORD_W  PC+4 of the fetched instruction, to IF/ID
instr_out  output  WORD_W  fetched instruction, to IF/ID
valid_out  output  1  IF/ID enable: load PC4_out/instr_out this edge
flush_out  output  1  IF/ID flush: zero latch this edge

Behaviour:
- State register: FETCH, REDIR_PEND, HALTED. Reset state is FETCH.
- Reset: PC=PC_INIT and pend_pc=0.
- Output gating: while nRST=1, imemREN, valid_out and flush_out are forced to 0.
- Combinational outputs: imemaddr=PC, PC4_out=PC+4 and instr_out=imemload in every state.
- Arithmetic: PC+4 wraps modulo 2^32. redirect_pc[1:0] is forced to 2'b00 before use.
- Priority within a cycle: halt > redirect > stall > normal.
- FETCH: imemREN=1.
  - halt=1: next state HALTED; PC holds; valid_out=0; flush_out=1.
  - redirect=1 and ihit=1: PC<=redirect_pc; valid_out=0; flush_out=1; stay in FETCH.
  - redirect=1 and ihit=0: the miss is in flight and the imem address must not change. pend_pc<=redirect_pc; flush_out=1; valid_out=0; next state REDIR_PEND; PC holds.
  - stall=1: PC holds; valid_out=0; flush_out=0. The IF/ID latch retains its contents.
  - ihit=1 (none of the above): PC<=PC+4; valid_out=1.
  - ihit=0 (none of the above): PC holds; valid_out=0.
- REDIR_PEND: imemREN=1; imemaddr stays at the old PC; valid_out=0. Returned data is discarded.
  - A new redirect overwrites pend_pc (newest wins) and asserts flush_out=1.
  - On ihit=1: PC<=pend_pc, using the new redirect_pc if one arrives this same cycle. Next state FETCH.
  - stall is ignored in this state.
  - halt=1: next state HALTED.
- HALTED: imemREN=0; valid_out=0; flush_out=0; PC frozen. Exit is by reset only.
- Latency: one instruction per cycle when ihit is continuously high. A redirect costs one bubble on a hit, or the remaining miss cycles plus one on a miss.
- Reset asserted mid-miss or in REDIR_PEND: state returns to FETCH and any pending redirect is lost.

Decomposition:
- cpu_types_pkg holds the fetch state enum (fetch_state_t: FETCH, REDIR_PEND, HALTED). word_t is already defined there.
- PC_INIT default lives in the package as a localparam.
- Single flat module; no sub-module is warranted.
- Optional fetch_if interface bundling the imem signals, matching the existing interface style.

Test Plan:
- Reset with PC_INIT=0, then ihit=1 for 4 cycles and imemload=0x2001_0005 -> imemaddr sequence 0,4,8,C; valid_out=1 each cycle; PC4_out=4,8,C,10.
- stall=1 for 2 cycles at PC=8 with ihit=1 -> PC stays 8; valid_out=0 and flush_out=0 for both cycles; after stall drops, imemaddr=8 then C.
- redirect=1 with redirect_pc=0x40 and ihit=1 at PC=C -> flush_out=1 and valid_out=0 that cycle; next imemaddr=0x40.
- redirect_pc=0x80 arrives while ihit=0 at PC=10, then ihit rises 3 cycles later -> state REDIR_PEND; imemaddr stays 10 throughout; valid_out=0; after ihit, imemaddr=0x80. A second redirect to 0x90 during the wait -> imemaddr becomes 0x90.
- halt=1 together with redirect=1 -> HALTED wins; imemREN=0 from the next cycle on; PC frozen; only reset (nRST=1) restarts fetch at PC_INIT.
- PC=0xFFFF_FFFC with ihit=1 -> PC4_out=0; next imemaddr=0. Also redirect_pc=0x43 -> next imemaddr=0x40.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the instruction-fetch state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_PEND = 2'd1,
        HALTED     = 2'd2
    } fetch_state_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem reads and the IF/ID latch
// controls, and parks redirects that arrive while an imem miss is in flight.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT,
    parameter int    WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] PC4_out,
    output logic [WORD_W-1:0] instr_out,
    output logic              valid_out,
    output logic              flush_out
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;
    word_t        rpc_aligned;
    logic         ren_raw, valid_raw, flush_raw;

    assign rpc_aligned = redirect_pc & ~32'h3;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        ren_raw   = 1'b0;
        valid_raw = 1'b0;
        flush_raw = 1'b0;
        case (state_q)
            FETCH: begin
                ren_raw = 1'b1;
                if (halt) begin
                    state_d   = HALTED;
                    flush_raw = 1'b1;
                end else if (redirect) begin
                    flush_raw = 1'b1;
                    if (ihit) begin
                        pc_d = rpc_aligned;
                    end else begin
                        // Miss in flight: the imem address must stay put until it returns.
                        pend_pc_d = rpc_aligned;
                        state_d   = REDIR_PEND;
                    end
                end else if (!stall && ihit) begin
                    pc_d      = pc_q + 32'd4;
                    valid_raw = 1'b1;
                end
            end
            REDIR_PEND: begin
                ren_raw = 1'b1;
                if (halt) begin
                    state_d = HALTED;
                end else begin
                    if (redirect) begin
                        flush_raw = 1'b1;
                        pend_pc_d = rpc_aligned;
                    end
                    if (ihit) begin
                        pc_d    = redirect ? rpc_aligned : pend_pc_q;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign imemREN   = ren_raw   & ~nRST;
    assign valid_out = valid_raw & ~nRST;
    assign flush_out = flush_raw & ~nRST;
    assign imemaddr  = pc_q;
    assign PC4_out   = pc_q + 32'd4;
    assign instr_out = imemload;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each driven cycle pushes its expected outputs,
// and an independent monitor pops and compares them on the falling edge.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] PC4_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        flush_out;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        int          step;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .imemload   (imemload),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .PC4_out    (PC4_out),
        .instr_out  (instr_out),
        .valid_out  (valid_out),
        .flush_out  (flush_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, step, act, req);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imemREN",   e.step, {31'd0, imemREN},   {31'd0, e.ren});
            chk("imemaddr",  e.step, imemaddr,           e.addr);
            chk("PC4_out",   e.step, PC4_out,            e.pc4);
            chk("instr_out", e.step, instr_out,          e.instr);
            chk("valid_out", e.step, {31'd0, valid_out}, {31'd0, e.valid});
            chk("flush_out", e.step, {31'd0, flush_out}, {31'd0, e.flush});
        end
    end

    task automatic step(input logic r, input logic ih, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic hl,
                        input logic e_ren, input logic [31:0] e_addr, input logic [31:0] e_pc4,
                        input logic e_v, input logic e_f);
        exp_t e;
        @(posedge CLK);
        #1;
        step_no++;
        nRST        = r;
        ihit        = ih;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        imemload    = 32'h2001_0005 ^ (step_no << 8);
        e.ren   = e_ren;
        e.addr  = e_addr;
        e.pc4   = e_pc4;
        e.instr = 32'h2001_0005 ^ (step_no << 8);
        e.valid = e_v;
        e.flush = e_f;
        e.step  = step_no;
        exp_q.push_back(e);
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; halt = 1'b0; imemload = '0;

        //    rst ih st rd rpc           hl  ren addr          pc4           v  f
        step(1, 1, 0, 0, 32'h0,        0,  0, 32'h0,        32'h4,        0, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h0,        32'h4,        1, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h4,        32'h8,        1, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h8,        32'hC,        1, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'hC,        32'h10,       1, 0);
        step(0, 1, 0, 1, 32'h8,        0,  1, 32'h10,       32'h14,       0, 1);
        // stall at PC=8
        step(0, 1, 1, 0, 32'h0,        0,  1, 32'h8,        32'hC,        0, 0);
        step(0, 1, 1, 0, 32'h0,        0,  1, 32'h8,        32'hC,        0, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h8,        32'hC,        1, 0);
        // redirect on a hit at PC=C
        step(0, 1, 0, 1, 32'h40,       0,  1, 32'hC,        32'h10,       0, 1);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h40,       32'h44,       1, 0);
        step(0, 1, 0, 1, 32'h10,       0,  1, 32'h44,       32'h48,       0, 1);
        // redirect during a miss at PC=10, overwritten by 0x90
        step(0, 0, 0, 1, 32'h80,       0,  1, 32'h10,       32'h14,       0, 1);
        step(0, 0, 1, 0, 32'h0,        0,  1, 32'h10,       32'h14,       0, 0);
        step(0, 0, 0, 1, 32'h90,       0,  1, 32'h10,       32'h14,       0, 1);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h10,       32'h14,       0, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h90,       32'h94,       1, 0);
        // redirect arriving on the same cycle the pending miss completes
        step(0, 0, 0, 1, 32'hA0,       0,  1, 32'h94,       32'h98,       0, 1);
        step(0, 1, 0, 1, 32'hB0,       0,  1, 32'h94,       32'h98,       0, 1);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'hB0,       32'hB4,       1, 0);
        // wrap-around and redirect alignment
        step(0, 1, 0, 1, 32'hFFFF_FFFF,0,  1, 32'hB4,       32'hB8,       0, 1);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'hFFFF_FFFC,32'h0,        1, 0);
        step(0, 1, 0, 1, 32'h43,       0,  1, 32'h0,        32'h4,        0, 1);
        step(0, 0, 0, 0, 32'h0,        0,  1, 32'h40,       32'h44,       0, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h40,       32'h44,       1, 0);
        // halt beats redirect; only reset leaves HALTED
        step(0, 1, 0, 1, 32'h200,      1,  1, 32'h44,       32'h48,       0, 1);
        step(0, 1, 0, 0, 32'h0,        0,  0, 32'h44,       32'h48,       0, 0);
        step(0, 1, 1, 1, 32'h300,      0,  0, 32'h44,       32'h48,       0, 0);
        step(1, 1, 0, 0, 32'h0,        0,  0, 32'h0,        32'h4,        0, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h0,        32'h4,        1, 0);
        // reset while a redirect is pending drops it
        step(0, 0, 0, 1, 32'h300,      0,  1, 32'h4,        32'h8,        0, 1);
        step(1, 1, 0, 0, 32'h0,        0,  0, 32'h0,        32'h4,        0, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h0,        32'h4,        1, 0);
        step(0, 1, 0, 0, 32'h0,        0,  1, 32'h4,        32'h8,        1, 0);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge CLK);
                budget++;
            end
            if (exp_q.size() > 0) begin
                checks++;
                failures++;
                $display("FAIL drain pending=%0d required=0", exp_q.size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
